phy_init_seq: RTL and testbench

PHY_INIT_SEQ -- requirements
Module: phy_init_seq

---
 rtl/phy_init_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_phy_init_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_init_seq.sv
// Brings an MDIO-attached PHY out of reset: soft reset, advertisement, autonegotiation,
// then keeps link_up current by polling the status register.
`timescale 1ns/1ps
module phy_init_seq #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [23:0] PWR_WAIT    = 24'd125000,
  parameter logic [23:0] POLL_GAP    = 24'd12500,
  parameter logic [7:0]  MAX_POLLS   = 8'd200,
  parameter logic [15:0] ADV_ABILITY = 16'h01E1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        init_done,
  output logic        link_up,
  output logic        fault
);

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_SRST_WR,
    ST_SRST_POLL,
    ST_ADV_WR,
    ST_AN_WR,
    ST_AN_POLL,
    ST_MONITOR,
    ST_FAULT
  } state_t;

  // PH_GAP is the idle countdown (power-up wait or poll spacing) before the next command.
  typedef enum logic [1:0] {
    PH_GAP,
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  localparam logic [7:0]  POLL_LIMIT = (MAX_POLLS == 8'd0) ? 8'd1 : MAX_POLLS;
  localparam logic [4:0]  REG_BMCR   = 5'd0;
  localparam logic [4:0]  REG_BMSR   = 5'd1;
  localparam logic [4:0]  REG_ANAR   = 5'd4;
  localparam logic [15:0] BMCR_RESET = 16'h8000;
  localparam logic [15:0] BMCR_AN    = 16'h1200;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [23:0] timer, timer_n;
  logic [7:0]  poll_cnt, poll_n;
  logic        valid_n, write_n, done_n, link_n, fault_n;
  logic [4:0]  reg_n;
  logic [15:0] wdata_n;

  logic        issue;
  logic        issue_write;
  logic [4:0]  issue_reg;
  logic [15:0] issue_data;

  logic        srst_clear;
  logic        an_complete;
  logic        unused_rdata;

  assign cmd_phy_addr = PHY_ADDR;
  assign srst_clear   = ~rsp_rdata[15];
  assign an_complete  = rsp_rdata[5] & rsp_rdata[2];
  assign unused_rdata = ^{rsp_rdata[14:6], rsp_rdata[4:3], rsp_rdata[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PWR_WAIT;
      phase        <= PH_GAP;
      timer        <= PWR_WAIT;
      poll_cnt     <= 8'd0;
      cmd_valid    <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_reg_addr <= 5'd0;
      cmd_wdata    <= 16'h0000;
      init_done    <= 1'b0;
      link_up      <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      timer        <= timer_n;
      poll_cnt     <= poll_n;
      cmd_valid    <= valid_n;
      cmd_write    <= write_n;
      cmd_reg_addr <= reg_n;
      cmd_wdata    <= wdata_n;
      init_done    <= done_n;
      link_up      <= link_n;
      fault        <= fault_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    timer_n     = timer;
    poll_n      = poll_cnt;
    valid_n     = cmd_valid;
    write_n     = cmd_write;
    reg_n       = cmd_reg_addr;
    wdata_n     = cmd_wdata;
    done_n      = init_done;
    link_n      = link_up;
    fault_n     = fault;
    issue       = 1'b0;
    issue_write = 1'b0;
    issue_reg   = REG_BMCR;
    issue_data  = 16'h0000;

    unique case (phase)
      PH_GAP: begin
        if (state == ST_FAULT) begin
          timer_n = 24'd0;
        end else if (timer != 24'd0) begin
          timer_n = timer - 24'd1;
        end else if (state == ST_PWR_WAIT) begin
          state_n     = ST_SRST_WR;
          issue       = 1'b1;
          issue_write = 1'b1;
          issue_reg   = REG_BMCR;
          issue_data  = BMCR_RESET;
        end else begin
          issue     = 1'b1;
          issue_reg = (state == ST_SRST_POLL) ? REG_BMCR : REG_BMSR;
          if (state != ST_MONITOR) begin
            poll_n = poll_cnt + 8'd1;
          end
        end
      end

      PH_ISSUE: begin
        if (cmd_ready) begin
          valid_n = 1'b0;
          phase_n = PH_WAIT;
        end
      end

      PH_WAIT: begin
        if (rsp_valid) begin
          // Default follow-up is another gap; states that issue or fault override it.
          phase_n = PH_GAP;
          timer_n = POLL_GAP;
          unique case (state)
            ST_SRST_WR: begin
              state_n = ST_SRST_POLL;
              poll_n  = 8'd0;
            end
            ST_SRST_POLL: begin
              if (srst_clear) begin
                state_n     = ST_ADV_WR;
                issue       = 1'b1;
                issue_write = 1'b1;
                issue_reg   = REG_ANAR;
                issue_data  = ADV_ABILITY;
              end else if (poll_cnt >= POLL_LIMIT) begin
                state_n = ST_FAULT;
              end
            end
            ST_ADV_WR: begin
              state_n     = ST_AN_WR;
              issue       = 1'b1;
              issue_write = 1'b1;
              issue_reg   = REG_BMCR;
              issue_data  = BMCR_AN;
            end
            ST_AN_WR: begin
              state_n = ST_AN_POLL;
              poll_n  = 8'd0;
            end
            ST_AN_POLL: begin
              if (an_complete) begin
                state_n = ST_MONITOR;
                done_n  = 1'b1;
                link_n  = 1'b1;
              end else if (poll_cnt >= POLL_LIMIT) begin
                state_n = ST_FAULT;
              end
            end
            ST_MONITOR: begin
              link_n = rsp_rdata[2];
            end
            default: begin
              phase_n = phase;
              timer_n = timer;
            end
          endcase
        end
      end

      default: begin
        phase_n = PH_GAP;
      end
    endcase

    if (issue) begin
      phase_n = PH_ISSUE;
      valid_n = 1'b1;
      write_n = issue_write;
      reg_n   = issue_reg;
      wdata_n = issue_data;
    end

    if (state_n == ST_FAULT) begin
      phase_n = PH_GAP;
      valid_n = 1'b0;
      done_n  = 1'b0;
      link_n  = 1'b0;
      fault_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_phy_init_seq.sv
// Directed-random bench for phy_init_seq: a sequential MDIO engine/PHY model answers each
// command while the expected command list is derived from the bring-up rules.
`timescale 1ns/1ps
module tb_phy_init_seq;

  localparam logic [4:0]  PHY_A = 5'd9;
  localparam logic [23:0] PW    = 24'd10;
  localparam logic [23:0] PG    = 24'd4;
  localparam logic [7:0]  MP    = 8'd5;
  localparam logic [15:0] ADV   = 16'h01E1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_rdata = 16'h0000;
  logic        cmd_valid, cmd_write, init_done, link_up, fault;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;

  typedef struct packed {
    logic        wr;
    logic [4:0]  ra;
    logic [15:0] wd;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  phy_init_seq #(
    .PHY_ADDR   (PHY_A),
    .PWR_WAIT   (PW),
    .POLL_GAP   (PG),
    .MAX_POLLS  (MP),
    .ADV_ABILITY(ADV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .link_up     (link_up),
    .fault       (fault)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] r1_nolink();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 1) == 0) v[5] = 1'b0;
    else v[2] = 1'b0;
    return v;
  endfunction

  function automatic logic [15:0] r1_link();
    logic [15:0] v;
    v = 16'($urandom);
    v[5] = 1'b1;
    v[2] = 1'b1;
    return v;
  endfunction

  // Reset, check cleared outputs, release, and drop a stray response right after release.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs",
                 32'({cmd_valid, cmd_write, cmd_reg_addr, cmd_wdata, init_done, link_up, fault}), 32'd0);
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 16'h0024;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_rdata = 16'($urandom);
  endtask

  task automatic take_cmd(input int stall, output cmd_t got, output int waited, output bit ok);
    bit stable;
    waited = 0;
    ok = 1'b1;
    got = '0;
    while (cmd_valid !== 1'b1 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_valid !== 1'b1) begin
      check_output("cmd_timeout", 32'(cmd_valid), 32'd1);
      ok = 1'b0;
      return;
    end
    got = {cmd_write, cmd_reg_addr, cmd_wdata};
    check_output("phy_addr", 32'(cmd_phy_addr), 32'(PHY_A));
    stable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || {cmd_write, cmd_reg_addr, cmd_wdata} !== got) stable = 1'b0;
    end
    check_output("stall_stable", 32'(stable), 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_output("valid_drop", 32'(cmd_valid), 32'd0);
  endtask

  task automatic respond(input int latency, input logic [15:0] data);
    bit quiet;
    quiet = 1'b1;
    repeat (latency - 1) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) quiet = 1'b0;
    end
    check_output("one_in_flight", 32'(quiet), 32'd1);
    rsp_valid = 1'b1;
    rsp_rdata = data;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_rdata = 16'($urandom);
  endtask

  // Expected command list: soft reset, reset polls, advertise, restart AN, status polls.
  task automatic run_init(input int srst_busy, input int an_fail, input bit fixed_timing,
                          input bit abort_an, output bit reached_monitor);
    cmd_t        e, got;
    int          waited, stall, lat, n_r1, r0n, r1n;
    bit          ok, first, quiet;
    logic [15:0] d;
    reached_monitor = 1'b0;
    r0n = 0;
    r1n = 0;
    first = 1'b1;
    exp_q.delete();
    exp_q.push_back({1'b1, 5'd0, 16'h8000});
    for (int i = 0; i <= srst_busy; i++) exp_q.push_back({1'b0, 5'd0, 16'h0000});
    exp_q.push_back({1'b1, 5'd4, ADV});
    exp_q.push_back({1'b1, 5'd0, 16'h1200});
    n_r1 = (an_fail >= int'(MP)) ? int'(MP) : an_fail + 1;
    for (int i = 0; i < n_r1; i++) exp_q.push_back({1'b0, 5'd1, 16'h0000});
    apply_reset();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      stall = fixed_timing ? 7 : int'($urandom_range(0, 7));
      lat = fixed_timing ? 20 : int'($urandom_range(1, 25));
      take_cmd(stall, got, waited, ok);
      if (!ok) return;
      if (first) check_output("pwr_wait_latency", 32'(waited + 1), 32'(PW) + 32'd1);
      check_output("cmd_fields", 32'(got), 32'(e));
      check_output("not_done_yet", 32'({init_done, fault}), 32'd0);
      if (!got.wr && !first) check_output("poll_gap", 32'(waited >= int'(PG)), 32'd1);
      if (!got.wr && got.ra == 5'd0) begin
        d = 16'($urandom);
        d[15] = (r0n < srst_busy);
        r0n++;
      end else if (!got.wr && got.ra == 5'd1) begin
        if (abort_an) begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          #2 rst_n = 1'b0;
          #1 check_output("async_reset",
                          32'({cmd_valid, cmd_write, cmd_reg_addr, cmd_wdata, init_done, link_up, fault}), 32'd0);
          return;
        end
        d = (r1n < an_fail) ? r1_nolink() : r1_link();
        r1n++;
      end else begin
        d = 16'($urandom);
      end
      respond(lat, d);
      first = 1'b0;
    end
    if (an_fail >= int'(MP)) begin
      check_output("fault_state", 32'({fault, init_done, link_up}), 32'b100);
      quiet = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (cmd_valid !== 1'b0 || fault !== 1'b1) quiet = 1'b0;
      end
      check_output("fault_terminal", 32'(quiet), 32'd1);
    end else begin
      check_output("init_state", 32'({fault, init_done, link_up}), 32'b011);
      reached_monitor = 1'b1;
    end
  endtask

  task automatic run_monitor();
    logic [15:0] vals[$];
    cmd_t        got;
    int          waited;
    bit          ok;
    vals = '{16'h0020, 16'h0024, 16'($urandom), 16'($urandom), 16'h0000};
    foreach (vals[i]) begin
      take_cmd(int'($urandom_range(0, 4)), got, waited, ok);
      if (!ok) return;
      check_output("mon_fields", 32'(got), 32'({1'b0, 5'd1, 16'h0000}));
      check_output("mon_gap", 32'(waited >= int'(PG)), 32'd1);
      respond(int'($urandom_range(1, 25)), vals[i]);
      check_output("mon_link", 32'({fault, init_done, link_up}), 32'({1'b0, 1'b1, vals[i][2]}));
    end
  endtask

  initial begin
    bit mon;
    $display("[TB] basic bring-up with fixed stalls and latency");
    run_init(0, 0, 1'b1, 1'b0, mon);
    if (mon) run_monitor();
    $display("[TB] soft reset busy three times");
    run_init(3, int'($urandom_range(0, 3)), 1'b0, 1'b0, mon);
    $display("[TB] autonegotiation never completes");
    run_init(int'($urandom_range(0, 2)), 9, 1'b0, 1'b0, mon);
    $display("[TB] reset during status poll, then full restart");
    run_init(int'($urandom_range(0, 2)), 1, 1'b0, 1'b1, mon);
    run_init(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0, 1'b0, mon);
    if (mon) run_monitor();
    $display("[TB] random bring-ups");
    repeat (3) begin
      run_init(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'b0, 1'b0, mon);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
